// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: keeps a single icache request in flight and buffers
// the returned words in a small circular queue, which the decoder drains.
module prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       icache_req,
  output logic [XLEN-1:0]            icache_addr,
  input  logic [31:0]                icache_data,
  input  logic                       icache_valid,
  output logic [31:0]                ir,
  output logic [XLEN-1:0]            ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [AW-1:0]     rptr, wptr;
  logic [31:0]       mem_d  [DEPTH];
  logic [XLEN-1:0]   mem_pc [DEPTH];

  logic              push, pop, issue_ok;
  logic [CW:0]       occ;
  logic [XLEN-1:0]   addr_inc;

  // occ is the queue occupancy after this cycle's push/pop; issuing only while
  // it is below DEPTH guarantees the next response always has a free slot.
  always_comb begin
    pop      = ir_valid && ir_ready;
    push     = (state == REQ) && icache_valid && !redirect;
    occ      = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    issue_ok = !stall && !redirect && (occ < DEPTH_W);
    addr_inc = icache_addr + XLEN'(4);
  end

  assign ir_valid = (count != '0);
  assign ir       = ir_valid ? mem_d[rptr]  : '0;
  assign ir_pc    = ir_valid ? mem_pc[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_d[wptr]  <= icache_data;
      mem_pc[wptr] <= icache_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      icache_req  <= 1'b0;
      icache_addr <= '0;
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
    end else begin
      if (redirect) begin
        rptr     <= '0;
        wptr     <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc & ~XLEN'(3);
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        count <= occ[CW-1:0];
      end

      case (state)
        IDLE: if (issue_ok) begin
          state       <= REQ;
          icache_req  <= 1'b1;
          icache_addr <= fetch_pc;
        end
        REQ: begin
          if (redirect) begin
            // A response landing with the redirect is simply dropped.
            if (icache_valid) begin
              state      <= IDLE;
              icache_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (icache_valid) begin
            fetch_pc <= addr_inc;
            if (issue_ok) begin
              icache_addr <= addr_inc;
            end else begin
              state      <= IDLE;
              icache_req <= 1'b0;
            end
          end
        end
        DROP: if (icache_valid) begin
          state      <= IDLE;
          icache_req <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          icache_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Scenario bench for prefetch_unit: bench-side icache model, scoreboard of
// expected {word, pc} pairs pushed on response and compared on each pop.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, icache_valid, ir_ready;
  logic [31:0] redirect_pc, icache_data;
  logic        icache_req, ir_valid;
  logic [31:0] icache_addr, ir, ir_pc;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_data(icache_data), .icache_valid(icache_valid), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    icache_valid = 1'b0; icache_data = '0; ir_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
    icache_valid = 1'b1; icache_data = 32'hDEAD_BEEF; ir_ready = 1'b1;
    tick(); tick();
    checks++;
    if (icache_req !== 1'b0 || ir_valid !== 1'b0 || count !== 3'd0 || ir !== 32'h0 || ir_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got req=%b ir_valid=%b count=%0d ir=%h ir_pc=%h, want all 0",
               icache_req, ir_valid, count, ir, ir_pc);
    end
    rst = 1'b1; redirect = 1'b0; icache_valid = 1'b0; ir_ready = 1'b0;
    tick();
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=00000000", icache_req, icache_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    exp_t        e;
    do_reset();
    ir_ready = 1'b1;
    tick();
    exp_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (icache_req !== 1'b1 || icache_addr !== exp_addr) begin
        failures++;
        $display("FAIL stream_addr[%0d]: got req=%b addr=%h, want req=1 addr=%h", i, icache_req, icache_addr, exp_addr);
      end
      checks++;
      if (count !== ((i == 0) ? 3'd0 : 3'd1)) begin
        failures++;
        $display("FAIL stream_count[%0d]: got %0d, want %0d", i, count, (i == 0) ? 0 : 1);
      end
      if (ir_valid && ir_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stream_pop[%0d]: got ir_pc=%h, want empty queue", i, ir_pc);
        end else begin
          e = sb.pop_front();
          if (ir !== e.d || ir_pc !== e.pc) begin
            failures++;
            $display("FAIL stream_pop[%0d]: got ir=%h pc=%h, want ir=%h pc=%h", i, ir, ir_pc, e.d, e.pc);
          end
        end
      end
      icache_valid = 1'b1;
      icache_data  = word_of(exp_addr);
      sb.push_back('{word_of(exp_addr), exp_addr});
      exp_addr += 32'd4;
      tick();
    end
    // Stall while the last request completes; nothing further may issue.
    stall = 1'b1;
    icache_data = word_of(icache_addr);
    sb.push_back('{word_of(icache_addr), icache_addr});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        icache_valid = 1'b0;
        checks++;
        if (icache_req !== 1'b0) begin
          failures++;
          $display("FAIL stall_no_req[%0d]: got req=%b, want 0", i, icache_req);
        end
      end
      if (ir_valid && ir_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL drain_pop[%0d]: got ir_pc=%h, want empty queue", i, ir_pc);
        end else begin
          e = sb.pop_front();
          if (ir !== e.d || ir_pc !== e.pc) begin
            failures++;
            $display("FAIL drain_pop[%0d]: got ir=%h pc=%h, want ir=%h pc=%h", i, ir, ir_pc, e.d, e.pc);
          end
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || count !== 3'd0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got count=%0d ir_valid=%b left=%0d, want 0 0 0", count, ir_valid, sb.size());
    end
  endtask

  task automatic test_full();
    int          pushes, reqs;
    exp_t        e;
    logic [31:0] held_ir, held_pc;
    do_reset();
    tick();
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      if (icache_req) begin
        icache_valid = 1'b1;
        icache_data  = word_of(icache_addr);
        sb.push_back('{word_of(icache_addr), icache_addr});
        pushes++;
      end else begin
        icache_valid = 1'b0;
      end
      tick();
    end
    icache_valid = 1'b0;
    checks++;
    if (pushes != 4 || count !== 3'd4 || icache_req !== 1'b0) begin
      failures++;
      $display("FAIL full_fill: got pushes=%0d count=%0d req=%b, want 4 4 0", pushes, count, icache_req);
    end
    held_ir = ir; held_pc = ir_pc;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ir !== held_ir || ir_pc !== 32'h0 || icache_req !== 1'b0 || ir_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_hold: got ir=%h pc=%h req=%b, want ir=%h pc=00000000 req=0", ir, ir_pc, icache_req, held_ir);
    end
    ir_ready = 1'b1;
    checks++;
    e = sb.pop_front();
    if (ir !== e.d || ir_pc !== e.pc) begin
      failures++;
      $display("FAIL full_pop: got ir=%h pc=%h, want ir=%h pc=%h", ir, ir_pc, e.d, e.pc);
    end
    tick();
    ir_ready = 1'b0;
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'h10 || count !== 3'd3 || ir_pc !== 32'h4) begin
      failures++;
      $display("FAIL full_refill_req: got req=%b addr=%h count=%0d pc=%h, want 1 00000010 3 00000004",
               icache_req, icache_addr, count, ir_pc);
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (icache_req) begin
        reqs++;
        icache_valid = 1'b1;
        icache_data  = word_of(icache_addr);
      end else begin
        icache_valid = 1'b0;
      end
      tick();
    end
    icache_valid = 1'b0;
    checks++;
    if (reqs != 1 || count !== 3'd4 || held_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_one_refill: got reqs=%0d count=%0d, want 1 4", reqs, count);
    end
  endtask

  task automatic test_redirect_drop();
    exp_t e;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin
        failures++;
        $display("FAIL drop_hold[%0d]: got req=%b addr=%h, want req=1 addr=00000000", i, icache_req, icache_addr);
      end
      if (i == 2) begin
        icache_valid = 1'b1;
        icache_data  = word_of(32'h0);
      end
      tick();
    end
    icache_valid = 1'b0;
    checks++;
    if (icache_req !== 1'b0 || count !== 3'd0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_discard: got req=%b count=%0d ir_valid=%b, want 0 0 0", icache_req, count, ir_valid);
    end
    tick();
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'h100) begin
      failures++;
      $display("FAIL drop_retarget: got req=%b addr=%h, want req=1 addr=00000100", icache_req, icache_addr);
    end
    icache_valid = 1'b1;
    icache_data  = word_of(32'h100);
    sb.push_back('{word_of(32'h100), 32'h100});
    tick();
    icache_valid = 1'b0;
    ir_ready = 1'b1;
    checks++;
    e = sb.pop_front();
    if (ir_valid !== 1'b1 || ir !== e.d || ir_pc !== e.pc) begin
      failures++;
      $display("FAIL drop_first_word: got v=%b ir=%h pc=%h, want v=1 ir=%h pc=%h", ir_valid, ir, ir_pc, e.d, e.pc);
    end
  endtask

  task automatic test_redirect_pop();
    exp_t e;
    do_reset();
    tick();
    icache_valid = 1'b1;
    icache_data  = word_of(32'h0);
    sb.push_back('{word_of(32'h0), 32'h0});
    tick();
    // Response, redirect and pop all land on the same edge.
    icache_data = word_of(icache_addr);
    redirect = 1'b1; redirect_pc = 32'h40; ir_ready = 1'b1;
    checks++;
    e = sb.pop_front();
    if (ir_valid !== 1'b1 || ir !== e.d || ir_pc !== e.pc || count !== 3'd1) begin
      failures++;
      $display("FAIL rp_head: got v=%b ir=%h pc=%h count=%0d, want v=1 ir=%h pc=%h count=1",
               ir_valid, ir, ir_pc, count, e.d, e.pc);
    end
    tick();
    icache_valid = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0 || icache_req !== 1'b0) begin
      failures++;
      $display("FAIL rp_flush: got count=%0d v=%b ir=%h pc=%h req=%b, want all 0",
               count, ir_valid, ir, ir_pc, icache_req);
    end
    tick();
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'h40) begin
      failures++;
      $display("FAIL rp_retarget: got req=%b addr=%h, want req=1 addr=00000040", icache_req, icache_addr);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0; ir_ready = 1'b1;
    checks++;
    if (icache_req !== 1'b0) begin
      failures++;
      $display("FAIL wrap_no_issue: got req=%b, want 0", icache_req);
    end
    tick();
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_first: got req=%b addr=%h, want req=1 addr=fffffffc", icache_req, icache_addr);
    end
    icache_valid = 1'b1;
    icache_data  = word_of(32'hFFFF_FFFC);
    sb.push_back('{word_of(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    tick();
    checks++;
    if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_second: got req=%b addr=%h, want req=1 addr=00000000", icache_req, icache_addr);
    end
    checks++;
    e = sb.pop_front();
    if (ir_valid !== 1'b1 || ir !== e.d || ir_pc !== e.pc) begin
      failures++;
      $display("FAIL wrap_pop: got v=%b ir=%h pc=%h, want v=1 ir=%h pc=%h", ir_valid, ir, ir_pc, e.d, e.pc);
    end
    icache_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    tick();
    icache_valid = 1'b1;
    icache_data  = word_of(32'h0);
    tick();
    icache_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (icache_req !== 1'b0 || count !== 3'd0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: got req=%b count=%0d v=%b, want 0 0 0", icache_req, count, ir_valid);
    end
    rst = 1'b1;
    icache_valid = 1'b1;
    icache_data  = 32'hBAD0_BAD0;
    tick();
    icache_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || ir_valid !== 1'b0 || icache_req !== 1'b1 || icache_addr !== 32'h0) begin
      failures++;
      $display("FAIL midrst_restart: got count=%0d v=%b req=%b addr=%h, want 0 0 1 00000000",
               count, ir_valid, icache_req, icache_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address and PC width.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: fetch PC loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
REQ-006 stall  input  1  when 1, no new icache request is issued; an outstanding request still completes.
REQ-007 redirect  input  1  one-cycle pulse that flushes the queue and retargets fetch.
REQ-008 redirect_pc  input  XLEN  new fetch target, sampled when redirect=1.
REQ-009 icache_req  output  1  icache request.
REQ-010 icache_addr  output  XLEN  request address.
REQ-011 icache_data  input  32  instruction word, valid when icache_valid=1.
REQ-012 icache_valid  input  1  one-cycle response strobe for the outstanding request.
REQ-013 ir  output  32  instruction at the queue head.
REQ-014 ir_pc  output  XLEN  PC of the queue head.
REQ-015 ir_valid  output  1  queue head holds an instruction.
REQ-016 ir_ready  input  1  consumer accepts the head; a pop occurs when ir_valid and ir_ready are both 1.
REQ-017 count  output  clog2(DEPTH+1)  number of occupied queue entries.

Function
REQ-018 FSM states SHALL be IDLE (no request outstanding), REQ (request outstanding) and DROP (stale request outstanding after a redirect).
REQ-019 icache_req SHALL be 1 exactly in REQ and DROP, and icache_addr SHALL stay constant from issue until the cycle icache_valid=1.
REQ-020 Issue condition: stall=0, redirect=0, and (count + outstanding + push - pop) < DEPTH, so every response always has a free slot.
REQ-021 IDLE -> REQ when the issue condition holds; icache_addr <= fetch_pc, and icache_req is 1 from the next cycle.
REQ-022 REQ with icache_valid=1: push {icache_data, icache_addr}; fetch_pc <= icache_addr+4.
REQ-023 In the same REQ/icache_valid cycle, if the issue condition holds: stay in REQ with icache_addr <= icache_addr+4 (back-to-back, one instruction per cycle); otherwise go to IDLE.
REQ-024 PC arithmetic SHALL be modulo 2^XLEN; 0xFFFFFFFC+4 wraps to 0.
REQ-025 redirect=1: flush the queue (count, read and write pointers to 0); fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-026 redirect in REQ with icache_valid=0 -> DROP.
REQ-027 redirect in REQ with icache_valid=1 -> discard the data and go to IDLE.
REQ-028 redirect in IDLE -> stay in IDLE.
REQ-029 A redirect cycle SHALL never push or issue.
REQ-030 DROP: keep icache_req and the old icache_addr until icache_valid=1, discard that data, then go to IDLE; a further redirect in DROP only updates fetch_pc.
REQ-031 Queue: circular buffer with log2(DEPTH)-bit read and write pointers wrapping DEPTH-1 -> 0; count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-032 A pop at full and a push into an empty queue in the same cycle SHALL both be legal.
REQ-033 Queue output SHALL be registered, with no bypass: a word pushed in cycle N appears at ir with ir_valid=1 in cycle N+1.
REQ-034 ir_valid SHALL equal (count != 0); ir and ir_pc SHALL be 0 when ir_valid=0.
REQ-035 A pop coinciding with redirect SHALL count as consumed; the flush still empties the queue.
REQ-036 ir and ir_pc SHALL hold stable while ir_valid=1 and ir_ready=0.

Reset
REQ-037 rst=0 at a rising edge: state IDLE, fetch_pc=RESET_PC, pointers=0, count=0, icache_req=0, ir_valid=0, ir=0, ir_pc=0.
REQ-038 Reset overrides redirect and any in-flight request; a request outstanding at reset is abandoned, and an icache_valid in the cycle after reset is ignored.
REQ-039 With stall=0, the first request (icache_addr=RESET_PC) SHALL be asserted in the second cycle after rst returns to 1.

Verification
REQ-040 Reset, stall=0, single-cycle icache, ir_ready=1 -> icache_addr 0,4,8,... one per cycle; ir_pc follows one cycle after each response.
REQ-041 ir_ready=0, DEPTH=4 -> exactly 4 pushes, count=4, icache_req=0 afterwards; one pop -> exactly one new request issued.
REQ-042 Redirect to 0x103 while a request is pending (icache_valid 3 cycles later) -> DROP, stale word not queued, next icache_addr=0x100.
REQ-043 Redirect coinciding with icache_valid and a pop -> count=0 next cycle, data dropped, next request at the redirect target.
REQ-044 redirect_pc=0xFFFFFFFC -> next two icache_addr values are 0xFFFFFFFC then 0x0.
REQ-045 rst=0 asserted mid-REQ, icache_valid arriving after reset -> queue stays empty, fetch restarts at RESET_PC.
